// File: rtl/coin_acceptor.sv
// Coin acceptor front end for vending_machine_fsm.
// Two raw, asynchronous, bouncy slot sensors (5 and 10) are synchronised and
// debounced. The debounced levels are then arbitrated by a small FSM. That FSM
// emits one registered coin_5 or coin_10 pulse for each accepted coin, or one
// reject pulse for each refused insertion. It also keeps a saturating running
// total of accepted value, in units of 5.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,  // legal range 2..255
    parameter int CNT_W           = 8,
    parameter int VALUE_W         = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               raw_coin_5,
    input  logic               raw_coin_10,
    input  logic               accept_en,
    output logic               coin_5,
    output logic               coin_10,
    output logic               reject,
    output logic [VALUE_W-1:0] total_value
);

    typedef enum logic {
        IDLE         = 1'b0,
        WAIT_RELEASE = 1'b1
    } state_t;

    // Counter value on the cycle just before the count would reach DEBOUNCE_CYCLES.
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel index 0 is the 5 slot and index 1 is the 10 slot.
    logic [1:0]            sync1;
    logic [1:0]            sync2;
    logic [1:0]            deb;
    logic [1:0]            deb_prev;
    logic [1:0][CNT_W-1:0] db_cnt;

    state_t               state;
    state_t               state_next;
    logic                 coin_5_next;
    logic                 coin_10_next;
    logic                 reject_next;
    logic [VALUE_W-1:0]   total_next;
    logic [VALUE_W:0]     total_sum;
    logic [VALUE_W:0]     total_inc;
    logic                 new_rise;

    // Two-flop synchroniser on both raw sensor levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {raw_coin_10, raw_coin_5};
            sync2 <= sync1;
        end
    end

    // Per-channel debounce. The debounced level follows sync2 only after
    // sync2 has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb      <= '0;
            deb_prev <= '0;
            db_cnt   <= '0;
        end else begin
            deb_prev <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        deb[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Saturating add of the value of the candidate coin: 1 for the 5 slot, 2 for the 10 slot.
    always_comb begin
        total_inc = deb[1] ? (VALUE_W + 1)'(2) : (VALUE_W + 1)'(1);
        total_sum = {1'b0, total_value} + total_inc;
    end

    // Arbitration FSM: decide on the insertion in IDLE, then wait for release.
    always_comb begin
        state_next   = state;
        coin_5_next  = 1'b0;
        coin_10_next = 1'b0;
        reject_next  = 1'b0;
        total_next   = total_value;
        new_rise     = (deb[0] & ~deb_prev[0]) | (deb[1] & ~deb_prev[1]);
        case (state)
            IDLE: begin
                if (deb[0] & deb[1]) begin
                    reject_next = 1'b1;
                    state_next  = WAIT_RELEASE;
                end else if (deb[0] | deb[1]) begin
                    if (accept_en) begin
                        coin_5_next  = deb[0];
                        coin_10_next = deb[1];
                        total_next   = total_sum[VALUE_W] ? '1 : total_sum[VALUE_W-1:0];
                    end else begin
                        reject_next = 1'b1;
                    end
                    state_next = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                // A second slot rising while the first is still held is refused once.
                if (new_rise) begin
                    reject_next = 1'b1;
                end
                if (deb == 2'b00) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            coin_5      <= 1'b0;
            coin_10     <= 1'b0;
            reject      <= 1'b0;
            total_value <= '0;
        end else begin
            state       <= state_next;
            coin_5      <= coin_5_next;
            coin_10     <= coin_10_next;
            reject      <= reject_next;
            total_value <= total_next;
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed testbench for coin_acceptor. It drives two instances with the same
// inputs: one with the default VALUE_W and one with VALUE_W=2, used to
// exercise saturation. Pulses are counted once per cycle, 1 time unit after
// each rising edge.
module tb_coin_acceptor;

    logic       clk;
    logic       reset;
    logic       raw_coin_5;
    logic       raw_coin_10;
    logic       accept_en;
    logic       coin_5;
    logic       coin_10;
    logic       reject;
    logic [7:0] total_value;
    logic       b_coin_5;
    logic       b_coin_10;
    logic       b_reject;
    logic [1:0] b_total_value;

    int n_vec;
    int n_err;
    int cyc;
    int c5;
    int c10;
    int rej;
    int b_c10;
    int excl_err;
    int t5;
    int t10;

    coin_acceptor dut (
        .clk         (clk),
        .reset       (reset),
        .raw_coin_5  (raw_coin_5),
        .raw_coin_10 (raw_coin_10),
        .accept_en   (accept_en),
        .coin_5      (coin_5),
        .coin_10     (coin_10),
        .reject      (reject),
        .total_value (total_value)
    );

    coin_acceptor #(.VALUE_W(2)) dut_sat (
        .clk         (clk),
        .reset       (reset),
        .raw_coin_5  (raw_coin_5),
        .raw_coin_10 (raw_coin_10),
        .accept_en   (accept_en),
        .coin_5      (b_coin_5),
        .coin_10     (b_coin_10),
        .reject      (b_reject),
        .total_value (b_total_value)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock, then tally pulses and check pulse exclusivity.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (coin_5)  begin c5++;  if (t5 < 0)  t5 = cyc; end
        if (coin_10) begin c10++; if (t10 < 0) t10 = cyc; end
        if (reject)  rej++;
        if (b_coin_10) b_c10++;
        if (int'(coin_5) + int'(coin_10) + int'(reject) > 1) excl_err++;
        if (int'(b_coin_5) + int'(b_coin_10) + int'(b_reject) > 1) excl_err++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_counts();
        cyc = 0; c5 = 0; c10 = 0; rej = 0; b_c10 = 0; t5 = -1; t10 = -1;
    endtask

    task automatic do_reset();
        raw_coin_5  = 1'b0;
        raw_coin_10 = 1'b0;
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        clear_counts();
    endtask

    task automatic insert(input bit is_10, input int high, input int low);
        if (is_10) raw_coin_10 = 1'b1; else raw_coin_5 = 1'b1;
        ticks(high);
        if (is_10) raw_coin_10 = 1'b0; else raw_coin_5 = 1'b0;
        ticks(low);
    endtask

    initial begin
        n_vec = 0; n_err = 0; excl_err = 0;
        raw_coin_5 = 1'b0; raw_coin_10 = 1'b0; accept_en = 1'b1; reset = 1'b1;
        clear_counts();
        #1;
        check("reset_coin_5", 32'(coin_5), 0);
        check("reset_coin_10", 32'(coin_10), 0);
        check("reset_reject", 32'(reject), 0);
        check("reset_total", 32'(total_value), 0);

        // Single 5 coin held for 20 cycles: pulse exactly at edge 6 (7th edge seen).
        do_reset();
        raw_coin_5 = 1'b1;
        ticks(6);
        check("t1_no_early_pulse", 32'(c5), 0);
        tick();
        check("t1_pulse_edge6", 32'(coin_5), 1);
        check("t1_total", 32'(total_value), 1);
        tick();
        check("t1_pulse_one_cycle", 32'(coin_5), 0);
        ticks(12);
        raw_coin_5 = 1'b0;
        ticks(12);
        check("t1_single_pulse", 32'(c5), 1);
        check("t1_no_reject", 32'(rej), 0);

        // Bouncing 10 coin, then isolated short glitches.
        do_reset();
        insert(1'b1, 2, 1);
        insert(1'b1, 2, 1);
        insert(1'b1, 10, 12);
        check("t2_bounce_one_coin_10", 32'(c10), 1);
        check("t2_total", 32'(total_value), 2);
        insert(1'b1, 1, 8);
        insert(1'b1, 2, 8);
        insert(1'b1, 3, 8);
        insert(1'b0, 3, 8);
        check("t2_glitch_no_coin_10", 32'(c10), 1);
        check("t2_glitch_no_coin_5", 32'(c5), 0);
        check("t2_glitch_no_reject", 32'(rej), 0);

        // A 5 coin followed by a 10 coin.
        do_reset();
        insert(1'b0, 12, 12);
        insert(1'b1, 12, 12);
        check("t3_coin_5", 32'(c5), 1);
        check("t3_coin_10", 32'(c10), 1);
        check("t3_order", 32'(t5 > 0 && t10 > t5), 1);
        check("t3_total", 32'(total_value), 3);
        check("t3_no_reject", 32'(rej), 0);

        // Both slots rise together, then a 10 arrives while a 5 is held.
        do_reset();
        raw_coin_5 = 1'b1; raw_coin_10 = 1'b1;
        ticks(12);
        raw_coin_5 = 1'b0; raw_coin_10 = 1'b0;
        ticks(12);
        check("t4_both_reject", 32'(rej), 1);
        check("t4_both_no_coin", 32'(c5 + c10), 0);
        check("t4_both_total", 32'(total_value), 0);
        clear_counts();
        raw_coin_5 = 1'b1;
        ticks(10);
        raw_coin_10 = 1'b1;
        ticks(12);
        raw_coin_5 = 1'b0; raw_coin_10 = 1'b0;
        ticks(12);
        check("t4_held_coin_5", 32'(c5), 1);
        check("t4_held_no_coin_10", 32'(c10), 0);
        check("t4_held_reject", 32'(rej), 1);
        check("t4_held_total", 32'(total_value), 1);

        // Acceptance disabled.
        do_reset();
        accept_en = 1'b0;
        insert(1'b0, 12, 12);
        check("t5_reject", 32'(rej), 1);
        check("t5_no_coin_5", 32'(c5), 0);
        check("t5_total", 32'(total_value), 0);
        accept_en = 1'b1;

        // Saturation with VALUE_W=2 alongside the default-width instance.
        do_reset();
        insert(1'b1, 12, 12);
        check("t6_sat_first", 32'(b_total_value), 2);
        insert(1'b1, 12, 12);
        check("t6_sat_clamped", 32'(b_total_value), 3);
        check("t6_sat_two_pulses", 32'(b_c10), 2);
        check("t6_wide_total", 32'(total_value), 4);

        // Reset while a coin pulse is in flight, coin still held afterwards.
        do_reset();
        raw_coin_5 = 1'b1;
        ticks(7);
        check("t7_pulse_before_reset", 32'(coin_5), 1);
        reset = 1'b1;
        #1;
        check("t7_reset_coin_5", 32'(coin_5), 0);
        check("t7_reset_total", 32'(total_value), 0);
        ticks(2);
        reset = 1'b0;
        clear_counts();
        ticks(12);
        check("t7_reaccept_coin_5", 32'(c5), 1);
        check("t7_reaccept_total", 32'(total_value), 1);
        raw_coin_5 = 1'b0;
        ticks(12);

        check("exclusive_pulses", 32'(excl_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
